// File: rtl/pid_alu_pkg.sv
// pid_alu_pkg: shared FSM state, mode word and saturation limits for the sequential PI ALU.
package pid_alu_pkg;
  typedef enum logic [1:0] {IDLE, ADD, MUL, DONE} state_e;
  typedef struct packed {
    logic multiply;
    logic sub;
    logic mult2;
    logic mult4;
    logic saturate;
  } mode_t;
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/pid_alu_mul_iter.sv
// pid_alu_mul_iter: radix-2 signed shift-add multiplier of two (W-1)-bit operands,
// one partial product per step, with fractional alignment and saturation of the result.
module pid_alu_mul_iter import pid_alu_pkg::*; #(
  parameter int W = 16,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-2:0] a,
  input  logic [W-2:0] b,
  output logic         last,
  output logic [W-1:0] res,
  output logic         ovf
);
  localparam int PW = 2 * W - 2;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MAXW = W'(sat_max(W));
  localparam logic [W-1:0] MINW = W'(sat_min(W));
  logic [PW-1:0] acc_q, acc_d, mc_q, mc_d, pp;
  logic [W-2:0] mp_q, mp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-W-FRAC:0] hi;
  logic adv, fits;
  always_comb begin
    last = cnt_q == CW'(W - 1);
    adv = step && !last;
    pp = mp_q[0] ? (cnt_q == CW'(W - 2) ? -mc_q : mc_q) : '0;
    acc_d = load ? '0 : adv ? acc_q + pp : acc_q;
    mc_d = load ? {{(PW-W+1){a[W-2]}}, a} : adv ? mc_q << 1 : mc_q;
    mp_d = load ? b : adv ? mp_q >> 1 : mp_q;
    cnt_d = load ? '0 : adv ? cnt_q + CW'(1) : cnt_q;
    hi = acc_q[PW-1:W+FRAC-1];
    fits = &hi || ~|hi;
    res = fits ? acc_q[W+FRAC-1:FRAC] : acc_q[PW-1] ? MINW : MAXW;
    ovf = !fits;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      mc_q <= '0;
      mp_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pid_alu_seq.sv
// pid_alu_seq: sequential PI-controller ALU; single-cycle add/subtract with scaling and
// optional saturation, iterative saturating fixed-point multiply, start/done handshake.
module pid_alu_seq import pid_alu_pkg::*; #(
  parameter int W = 16,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src0,
  input  logic         multiply,
  input  logic         sub,
  input  logic         mult2,
  input  logic         mult4,
  input  logic         saturate,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dst,
  output logic         ovf
);
  localparam logic signed [W+2:0] MAX3 = (W+3)'(sat_max(W));
  localparam logic signed [W+2:0] MIN3 = (W+3)'(sat_min(W));
  localparam logic [W-1:0] MAXW = W'(sat_max(W));
  localparam logic [W-1:0] MINW = W'(sat_min(W));
  if (W < 8 || W + FRAC > 2 * W - 2) begin : g_bad_params
    $error("pid_alu_seq: need W >= 8 and W+FRAC <= 2W-2");
  end
  state_e state_q, state_d;
  mode_t mode_q, mode_d;
  logic [W-1:0] src1_q, src1_d, src0_q, src0_d, dst_q, dst_d, add_res, mul_res;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic accept, fin, mul_load, mul_last, mul_ovf, add_hi, add_lo, add_ovf;
  logic [1:0] sh;
  logic signed [W+2:0] s0, sum;
  pid_alu_mul_iter #(.W(W), .FRAC(FRAC)) u_mul (
    .clk(clk), .rst(rst), .load(mul_load), .step(state_q == MUL),
    .a(src1[W-2:0]), .b(src0[W-2:0]), .last(mul_last), .res(mul_res), .ovf(mul_ovf)
  );
  always_comb begin
    accept = state_q == IDLE && start;
    mul_load = accept && multiply;
    fin = state_q == ADD || (state_q == MUL && mul_last);
    sh = mode_q.mult4 ? 2'd2 : mode_q.mult2 ? 2'd1 : 2'd0;
    s0 = {{3{src0_q[W-1]}}, src0_q} << sh;
    sum = {{3{src1_q[W-1]}}, src1_q} + (mode_q.sub ? -s0 : s0);
    add_hi = mode_q.saturate && sum > MAX3;
    add_lo = mode_q.saturate && sum < MIN3;
    add_res = add_hi ? MAXW : add_lo ? MINW : sum[W-1:0];
    add_ovf = add_hi || add_lo;
    state_d = accept ? (multiply ? MUL : ADD) : fin ? DONE : state_q == DONE ? IDLE : state_q;
    busy_d = accept || (busy_q && state_q != DONE);
    done_d = fin;
    dst_d = fin ? (mode_q.multiply ? mul_res : add_res) : dst_q;
    ovf_d = fin ? (mode_q.multiply ? mul_ovf : add_ovf) : ovf_q;
    src1_d = accept ? src1 : src1_q;
    src0_d = accept ? src0 : src0_q;
    mode_d = accept ? mode_t'{multiply, sub, mult2, mult4, saturate} : mode_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dst_q <= '0;
      ovf_q <= 1'b0;
      src1_q <= '0;
      src0_q <= '0;
      mode_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dst_q <= dst_d;
      ovf_q <= ovf_d;
      src1_q <= src1_d;
      src0_q <= src0_d;
      mode_q <= mode_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign dst = dst_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pid_alu_seq.sv
// tb_pid_alu_seq: directed checks of add/sub/saturate, iterative multiply, handshake and async reset.
module tb_pid_alu_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] src1 = '0, src0 = '0;
  logic multiply = 1'b0, sub = 1'b0, mult2 = 1'b0, mult4 = 1'b0, saturate = 1'b0;
  logic busy, done, ovf;
  logic [15:0] dst;
  int total = 0, bad = 0;
  int n, dcnt;
  logic busy_ok;
  pid_alu_seq #(.W(16), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .start(start), .src1(src1), .src0(src0),
    .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4), .saturate(saturate),
    .busy(busy), .done(done), .dst(dst), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setop(input logic [15:0] a, input logic [15:0] b, input logic m, input logic s,
                       input logic m2, input logic m4, input logic sat);
    src1 = a; src0 = b; multiply = m; sub = s; mult2 = m2; mult4 = m4; saturate = sat;
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic s, input logic m2, input logic m4,
                        input logic sat, input logic [15:0] edst, input logic eovf, input int elat);
    setop(a, b, m, s, m2, m4, sat);
    start = 1'b1;
    tick();
    start = 1'b0;
    setop(16'h5555, 16'h2AAA, !m, !s, 1'b1, 1'b0, !sat);
    n = 1;
    busy_ok = busy;
    while (!done && n < 40) begin
      tick();
      n++;
      busy_ok &= busy;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " busy"}, {31'd0, busy_ok}, 1);
    check({tag, " dst"}, {16'd0, dst}, {16'd0, edst});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
    tick();
    check({tag, " idle"}, {30'd0, busy, done}, 0);
  endtask
  initial begin
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset dst", {16'd0, dst}, 0);
    check("reset ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    tick();
    run_op("add sat", 16'h7000, 16'h2000, 0, 0, 0, 0, 1, 16'h7FFF, 1, 2);
    run_op("add wrap", 16'h7000, 16'h2000, 0, 0, 0, 0, 0, 16'h9000, 0, 2);
    run_op("sub x4", 16'h0010, 16'h0004, 0, 1, 0, 1, 0, 16'h0000, 0, 2);
    run_op("sub x4 prio", 16'h0010, 16'h0004, 0, 1, 1, 1, 0, 16'h0000, 0, 2);
    run_op("add x2", 16'h0100, 16'h0003, 0, 0, 1, 0, 0, 16'h0106, 0, 2);
    run_op("sub sat neg", 16'h8000, 16'h0001, 0, 1, 0, 0, 1, 16'h8000, 1, 2);
    run_op("mul pos", 16'h1000, 16'h0800, 1, 0, 0, 0, 0, 16'h0800, 0, 17);
    run_op("mul neg", 16'h7000, 16'h1000, 1, 0, 0, 0, 0, 16'hF000, 0, 17);
    run_op("mul ovf pos", 16'h3FFF, 16'h3FFF, 1, 0, 0, 0, 0, 16'h7FFF, 1, 17);
    run_op("mul ovf neg", 16'h3FFF, 16'h4001, 1, 0, 0, 0, 0, 16'h8000, 1, 17);
    // restart attempts every cycle of a multiply must not disturb it
    setop(16'h1000, 16'h0800, 1, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    setop(16'h3FFF, 16'h3FFF, 1, 0, 0, 0, 1);
    n = 1;
    dcnt = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    dcnt += int'(done);
    check("hs latency", n, 17);
    check("hs done count", dcnt, 1);
    check("hs dst", {16'd0, dst}, 32'h0800);
    check("hs ovf", {31'd0, ovf}, 0);
    setop(16'h0005, 16'h0003, 0, 0, 0, 0, 0);
    tick();
    check("hs done-cycle start ignored", {30'd0, busy, done}, 0);
    tick();
    start = 1'b0;
    check("hs next start accepted", {31'd0, busy}, 1);
    tick();
    check("hs add done", {31'd0, done}, 1);
    check("hs add dst", {16'd0, dst}, 32'h0008);
    tick();
    run_op("pre-reset", 16'h8000, 16'h0001, 0, 1, 0, 0, 1, 16'h8000, 1, 2);
    setop(16'h3FFF, 16'h3FFF, 1, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    check("rst busy", {31'd0, busy}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst dst", {16'd0, dst}, 0);
    check("rst ovf", {31'd0, ovf}, 0);
    tick();
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      dcnt += int'(done | busy);
    end
    check("rst no done", dcnt, 0);
    run_op("post-reset add", 16'h0123, 16'h0100, 0, 0, 0, 0, 0, 16'h0223, 0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pid_alu_seq.md
Name: pid_alu_seq

Overview:
- Parametrised, sequential successor to the combinational PI-controller ALU.
- Takes two pre-selected operands and a mode word on a start/done handshake. Add/subtract completes in 1 cycle; signed fixed-point multiply runs iteratively over W-1 cycles.
- Width, fractional alignment and saturation are generic, with overflow reported per operation.
- Sits between the controller's source-select muxes and the accumulator/term registers.

Parameters:
- W, 16, datapath width of operands and result (>= 8).
- FRAC, 12, fractional bits dropped from the product; multiply result = product[W+FRAC-1:FRAC].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- src1  input  W  operand 1 (signed).
- src0  input  W  operand 0 (signed).
- multiply  input  1  1 = iterative multiply; 0 = add path.
- sub  input  1  add path: dst = src1 - scaled src0.
- mult2  input  1  add path: scale src0 by 2.
- mult4  input  1  add path: scale src0 by 4; overrides mult2.
- saturate  input  1  add path: clip to signed W range; multiply always saturates.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; dst/ovf valid from this cycle.
- dst  output  W  result, held until next done.
- ovf  output  1  set with done if clipping occurred, held with dst.

Behaviour:
- Reset (async, any state): busy=0, done=0, dst=0, ovf=0; FSM forced to IDLE. Internal product/counter cleared. An in-flight operation is discarded and never completes.
- Input capture: operands and mode bits are captured at the start-accept edge. Later input changes do not affect the operation.
- FSM states:
  - IDLE: start=1 and multiply=0 -> ADD. start=1 and multiply=1 -> MUL (load multiplicand/multiplier, counter=0).
  - ADD: one cycle -> DONE.
  - MUL: one shift-add step per cycle, W-1 steps; after the last step -> DONE.
  - DONE: register dst/ovf, pulse done -> IDLE.
- busy: high from the cycle after accept until the cycle done pulses (inclusive).
- Latency from the accept edge: add path, done in cycle 2; multiply, done in cycle W+1 (17 for W=16).
- start while busy=1 is ignored, with no queueing. start in the same cycle as done is also ignored; it may be accepted the next cycle.
- Add path arithmetic, in W+3 bits, sign extended:
  - s0 = src0 << (mult4 ? 2 : mult2 ? 1 : 0).
  - sum = src1 + (sub ? -s0 : s0).
  - saturate=1: sum > 2^(W-1)-1 -> dst=2^(W-1)-1, ovf=1; sum < -2^(W-1) -> dst=-2^(W-1), ovf=1; otherwise dst=sum[W-1:0].
  - saturate=0: dst=sum[W-1:0], ovf=0.
- Multiply arithmetic:
  - Operands are src1[W-2:0] and src0[W-2:0], each a signed (W-1)-bit value.
  - Product p is 2W-2 bits, computed by radix-2 signed shift-add. The final step subtracts for the sign bit.
  - If p[2W-3:W+FRAC-1] is all equal, dst = p[W+FRAC-1:FRAC].
  - Otherwise saturate on the sign of p[2W-3]: positive -> 2^(W-1)-1, negative -> -2^(W-1); ovf=1.
  - Elaboration check: W+FRAC <= 2W-2.
- The result must equal the combinational multiply of the predecessor ALU for W=16, FRAC=12.

Decomposition:
- Shared package pid_alu_pkg:
  - FSM state enum {IDLE, ADD, MUL, DONE}.
  - Mode-word struct (multiply, sub, mult2, mult4, saturate).
  - Saturation-limit functions sat_max(W) and sat_min(W).
- One sub-module: pid_alu_mul_iter, the iterative signed multiplier (load/step/last signals, counter, product register). FSM and add path stay in the top module.

Test Plan:
- Add, saturated (W=16): src1=16'h7000, src0=16'h2000, saturate=1 -> dst=16'h7FFF, ovf=1, done exactly 2 cycles after accept. Same with saturate=0 -> dst=16'h9000, ovf=0.
- Subtract with scale: src1=16'h0010, src0=16'h0004, sub=1, mult4=1 -> dst=16'h0000. Repeat with mult2=1 and mult4=1 -> still 16'h0000 (mult4 priority). src1=16'h8000, src0=16'h0001, sub=1, saturate=1 -> dst=16'h8000, ovf=1.
- Multiply: src1=16'h1000, src0=16'h0800 -> dst=16'h0800, ovf=0. done on cycle 17 after accept; busy high cycles 1-17. src1=16'h7000 (-4096 in 15 bits), src0=16'h1000 -> dst=16'hF000.
- Multiply overflow: src1=16'h3FFF, src0=16'h3FFF -> dst=16'h7FFF, ovf=1. src1=16'h3FFF, src0=16'h4001 -> dst=16'h8000, ovf=1.
- Handshake: start pulsed every cycle during a multiply -> exactly one done, dst from the first operands only. start in the done cycle ignored; start the next cycle accepted.
- Reset mid-multiply: rst asserted 5 cycles after accept, asynchronously mid-cycle -> busy, done, dst, ovf = 0 immediately, no later done. After release, a fresh add completes correctly.
